m1rstseq: RTL

- Reset sequencer for the clock/reset generator domain.
- Waits for both DDR PHY PLLs to report lock, then releases the off-chip and on-chip resets in a fixed order: Flash first, system last.
- Arbitrates reset requests from software, PLL lock loss and an optional watchdog, and records the cause of the last reset for the CSR bank.

---
 rtl/m1rstseq_if.sv | 51 +++++
 rtl/m1rstseq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/m1rstseq_if.sv
// rtl/m1rstseq_if.sv - reset sequencer request/reset signal bundle
//
// Groups the software request, the generated resets and the status outputs
// of the reset sequencer.
//   trigger_reset  software reset request, level, sys_clk domain
//   sys_rst        system reset, active-high
//   flash_rst_n    Flash reset, active-low
//   ac97_rst_n     AC97 codec reset, active-low
//   videoin_rst_n  video-in reset, active-low
//   busy           high while the sequence is not in RUN
//   rst_cause      0 power-on, 1 software, 2 lock loss, 3 watchdog
//   wdt_kick       watchdog restart pulse (only with M1RSTSEQ_WATCHDOG_EN)
// master: the sequencer; slave: the consumer of the resets/status.
interface m1rstseq_if;
  logic       trigger_reset;
  logic       sys_rst;
  logic       flash_rst_n;
  logic       ac97_rst_n;
  logic       videoin_rst_n;
  logic       busy;
  logic [1:0] rst_cause;
`ifdef M1RSTSEQ_WATCHDOG_EN
  logic       wdt_kick;
`endif

  modport master (
`ifdef M1RSTSEQ_WATCHDOG_EN
    input  wdt_kick,
`endif
    input  trigger_reset,
    output sys_rst,
    output flash_rst_n,
    output ac97_rst_n,
    output videoin_rst_n,
    output busy,
    output rst_cause
  );

  modport slave (
`ifdef M1RSTSEQ_WATCHDOG_EN
    output wdt_kick,
`endif
    output trigger_reset,
    input  sys_rst,
    input  flash_rst_n,
    input  ac97_rst_n,
    input  videoin_rst_n,
    input  busy,
    input  rst_cause
  );
endinterface

// File: rtl/m1rstseq.sv
// rtl/m1rstseq.sv - PLL-lock driven reset sequencer (Flash first, system last)
//
// Waits for both PLL locks to be stable, then releases flash_rst_n, and later
// sys_rst / ac97_rst_n / videoin_rst_n. Lock loss, software request and the
// optional watchdog (macro M1RSTSEQ_WATCHDOG_EN) restart the sequence and
// record the cause.
//   sys_clk      system clock, rising edge
//   reset_n      asynchronous active-low reset
//   pll1_locked  PLL1 lock, asynchronous
//   pll2_locked  PLL2 lock, asynchronous
//   bus          m1rstseq_if.master: trigger_reset, resets, busy, rst_cause,
//                wdt_kick (watchdog build only)
module m1rstseq #(
  parameter int CNT_W        = 20,
  parameter int LOCK_STABLE  = 16,
  parameter int FLASH_CYCLES = 128,
  parameter int SYS_CYCLES   = 1048575,
  parameter int WDT_CYCLES   = 67108863
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       pll1_locked,
  input  logic       pll2_locked,
  m1rstseq_if.master bus
);

  if (LOCK_STABLE < 1 || FLASH_CYCLES < 1 || SYS_CYCLES < 1 || WDT_CYCLES < 1 ||
      longint'(LOCK_STABLE)  >= (longint'(1) << CNT_W) ||
      longint'(FLASH_CYCLES) >= (longint'(1) << CNT_W) ||
      longint'(SYS_CYCLES)   >= (longint'(1) << CNT_W)) begin : g_param_check
    $error("m1rstseq: phase length out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST   = CNT_W'(SYS_CYCLES - 1);

  typedef enum logic [1:0] {LOCKWAIT, FLASH, SYS, RUN} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]       cause, cause_nx;
  logic             p1_meta, p1_sync, p2_meta, p2_sync;
  logic             lk;
  logic             wdt_expire;
  logic             sys_rst_q, flash_rst_n_q, periph_rst_n_q, busy_q;

  // Two-flop synchronisers; lk therefore trails the pins by two cycles.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_meta <= 1'b0;
      p1_sync <= 1'b0;
      p2_meta <= 1'b0;
      p2_sync <= 1'b0;
    end else begin
      p1_meta <= pll1_locked;
      p1_sync <= p1_meta;
      p2_meta <= pll2_locked;
      p2_sync <= p2_meta;
    end
  end

  assign lk = p1_sync & p2_sync;

`ifdef M1RSTSEQ_WATCHDOG_EN
  localparam int             WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_cnt;

  // A kick in the expiry cycle wins over the timeout.
  assign wdt_expire = (state == RUN) && !bus.wdt_kick && (wdt_cnt == WDT_LAST);

  // Runs only while staying in RUN; any exit from RUN restarts it.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt <= '0;
    end else if (state != RUN || state_nx != RUN || bus.wdt_kick) begin
      wdt_cnt <= '0;
    end else begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end
`else
  assign wdt_expire = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cause_nx = cause;
    if (state == LOCKWAIT) begin
      // Software requests are ignored here; only lock stability matters.
      if (!lk) begin
        cnt_nx = '0;
      end else if (cnt == LOCK_LAST) begin
        cnt_nx   = '0;
        state_nx = FLASH;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end else if (!lk) begin
      state_nx = LOCKWAIT;
      cnt_nx   = '0;
      cause_nx = 2'd2;
    end else if (wdt_expire) begin
      state_nx = FLASH;
      cnt_nx   = '0;
      cause_nx = 2'd3;
    end else if (bus.trigger_reset) begin
      // Holding the request keeps restarting FLASH.
      state_nx = FLASH;
      cnt_nx   = '0;
      cause_nx = 2'd1;
    end else if (state == FLASH) begin
      if (cnt == FLASH_LAST) begin
        cnt_nx   = '0;
        state_nx = SYS;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end else if (state == SYS) begin
      if (cnt == SYS_LAST) begin
        cnt_nx   = '0;
        state_nx = RUN;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= LOCKWAIT;
      cnt            <= '0;
      cause          <= 2'd0;
      sys_rst_q      <= 1'b1;
      flash_rst_n_q  <= 1'b0;
      periph_rst_n_q <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      cause          <= cause_nx;
      sys_rst_q      <= (state_nx != RUN);
      flash_rst_n_q  <= (state_nx == SYS) || (state_nx == RUN);
      periph_rst_n_q <= (state_nx == RUN);
      busy_q         <= (state_nx != RUN);
    end
  end

  assign bus.sys_rst       = sys_rst_q;
  assign bus.flash_rst_n   = flash_rst_n_q;
  assign bus.ac97_rst_n    = periph_rst_n_q;
  assign bus.videoin_rst_n = periph_rst_n_q;
  assign bus.busy          = busy_q;
  assign bus.rst_cause     = cause;

endmodule
